// File: rtl/fpmu_pkg.sv
// Shared FP16 multiplier constants, FSM state type and flag bit positions.
// Imported by fpmu_norm_round_pack and fpmu_round_rne.
package fpmu_pkg;

   localparam int unsigned FP16_EXP_W  = 5;
   localparam int unsigned FP16_MANT_W = 10;
   localparam int unsigned FP16_BIAS   = 15;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_INF  = 16'h7C00;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} fpmu_state_e;

   localparam int unsigned FLAG_INEXACT   = 0;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_INVALID   = 3;

endpackage

// File: rtl/fpmu_round_rne.sv
// Combinational round-to-nearest-even on a hidden-bit mantissa with guard/sticky.
// A carry-out renormalises the mantissa to 1.000...; the caller bumps the exponent.
module fpmu_round_rne
   import fpmu_pkg::*;
#(
   parameter int unsigned MANT_W = FP16_MANT_W
) (
   input  logic [MANT_W:0] i_mant,
   input  logic            i_guard,
   input  logic            i_sticky,
   output logic [MANT_W:0] o_mant,
   output logic            o_carry,
   output logic            o_inexact
);

   logic              w_up;
   logic [MANT_W+1:0] w_sum;

   assign w_up      = i_guard & (i_sticky | i_mant[0]);
   assign w_sum     = {1'b0, i_mant} + (MANT_W + 2)'(w_up);
   assign o_carry   = w_sum[MANT_W+1];
   assign o_mant    = o_carry ? {1'b1, {MANT_W{1'b0}}} : w_sum[MANT_W:0];
   assign o_inexact = i_guard | i_sticky;

endmodule

// File: rtl/fpmu_norm_round_pack.sv
// FP16 multiplier back end: normalise, unbias, round RNE, saturate and pack.
// Define FPMU_FLAGS_EN to add the o_flags {invalid, overflow, underflow, inexact} port.
module fpmu_norm_round_pack
   import fpmu_pkg::*;
#(
   parameter int unsigned EXP_W    = FP16_EXP_W,
   parameter int unsigned MANT_W   = FP16_MANT_W,
   parameter int unsigned EXP_BIAS = FP16_BIAS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [2*MANT_W+1:0]     i_prod_mant,
   input  logic [EXP_W:0]          i_exp_sum,
   input  logic                    i_sign,
   input  logic                    i_in_zero,
   input  logic                    i_in_inf,
   input  logic                    i_in_nan,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [EXP_W+MANT_W:0]   o_result
`ifdef FPMU_FLAGS_EN
   ,
   output logic [3:0]              o_flags
`endif
);

   localparam int unsigned PROD_W = 2 * MANT_W + 2;
   localparam int unsigned E_W    = EXP_W + 2;
   localparam int unsigned RES_W  = EXP_W + MANT_W + 1;
   localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
   localparam logic signed [E_W-1:0] E_ZERO = '0;

   fpmu_state_e r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [RES_W-1:0]   r_result;
   logic [PROD_W-1:0]  r_prod;
   logic [EXP_W:0]     r_exp_sum;
   logic               r_sign;
   logic               r_zero;
   logic               r_inf;
   logic               r_nan;
   logic [MANT_W:0]    r_mant;
   logic               r_guard;
   logic               r_sticky;
   logic signed [E_W-1:0] r_e;

   logic               w_norm_hi;
   logic [MANT_W:0]    w_norm_mant;
   logic               w_norm_guard;
   logic               w_norm_sticky;
   logic [E_W-1:0]     w_norm_e;

   logic [MANT_W:0]    w_rnd_mant;
   logic               w_rnd_carry;
   logic               w_rnd_inexact;
   logic signed [E_W-1:0] w_rnd_e;
   logic               w_ovf;
   logic               w_unf;
   logic [RES_W-1:0]   w_res;

   // Bit PROD_W-1 set means the product is in [2,4): shift one further right.
   assign w_norm_hi     = r_prod[PROD_W-1];
   assign w_norm_mant   = w_norm_hi ? r_prod[PROD_W-1 -: MANT_W+1] : r_prod[PROD_W-2 -: MANT_W+1];
   assign w_norm_guard  = w_norm_hi ? r_prod[MANT_W] : r_prod[MANT_W-1];
   assign w_norm_sticky = w_norm_hi ? (|r_prod[MANT_W-1:0]) : (|r_prod[MANT_W-2:0]);
   assign w_norm_e      = {1'b0, r_exp_sum} - E_W'(EXP_BIAS) + E_W'(w_norm_hi);

   fpmu_round_rne #(
      .MANT_W (MANT_W)
   ) u_round (
      .i_mant    (r_mant),
      .i_guard   (r_guard),
      .i_sticky  (r_sticky),
      .o_mant    (w_rnd_mant),
      .o_carry   (w_rnd_carry),
      .o_inexact (w_rnd_inexact)
   );

   assign w_rnd_e = r_e + $signed(E_W'(w_rnd_carry));
   assign w_ovf   = (w_rnd_e >= E_MAX);
   assign w_unf   = (w_rnd_e <= E_ZERO);

   always_comb begin
      w_res = {r_sign, w_rnd_e[EXP_W-1:0], w_rnd_mant[MANT_W-1:0]};
      if (r_nan || (r_inf && r_zero)) begin
         w_res = FP16_QNAN;
      end else if (r_inf) begin
         w_res = {r_sign, FP16_INF[RES_W-2:0]};
      end else if (r_zero) begin
         w_res = {r_sign, {(RES_W-1){1'b0}}};
      end else if (w_ovf) begin
         w_res = {r_sign, FP16_INF[RES_W-2:0]};
      end else if (w_unf) begin
         w_res = {r_sign, {(RES_W-1){1'b0}}};
      end
   end

`ifdef FPMU_FLAGS_EN
   logic [3:0] r_flags;
   logic [3:0] w_flags;

   // Specials (NaN, inf, zero operands) are exact; only finite paths report inexact.
   always_comb begin
      w_flags = '0;
      if (r_nan || (r_inf && r_zero)) begin
         w_flags[FLAG_INVALID] = 1'b1;
      end else if (!r_inf && !r_zero) begin
         w_flags[FLAG_OVERFLOW]  = w_ovf;
         w_flags[FLAG_UNDERFLOW] = w_unf && !w_ovf;
         w_flags[FLAG_INEXACT]   = w_rnd_inexact | w_ovf | w_unf;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_flags <= '0;
      end else if (r_state == ROUND) begin
         r_flags <= w_flags;
      end
   end

   assign o_flags = r_flags;
`else
   logic w_unused_inexact;
   assign w_unused_inexact = w_rnd_inexact;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_in_valid && r_in_ready) begin
                  r_prod     <= i_prod_mant;
                  r_exp_sum  <= i_exp_sum;
                  r_sign     <= i_sign;
                  r_zero     <= i_in_zero;
                  r_inf      <= i_in_inf;
                  r_nan      <= i_in_nan;
                  r_in_ready <= 1'b0;
                  r_state    <= NORM;
               end
            end
            NORM: begin
               r_mant   <= w_norm_mant;
               r_guard  <= w_norm_guard;
               r_sticky <= w_norm_sticky;
               r_e      <= $signed(w_norm_e);
               r_state  <= ROUND;
            end
            ROUND: begin
               r_result    <= w_res;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;

endmodule

// File: tb/tb_fpmu_norm_round_pack.sv
// Scoreboard bench for fpmu_norm_round_pack: directed vectors push expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_fpmu_norm_round_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [21:0] prod_mant;
   logic [5:0]  exp_sum;
   logic        sign;
   logic        in_zero;
   logic        in_inf;
   logic        in_nan;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
`ifdef FPMU_FLAGS_EN
   logic [3:0]  flags;
`endif

   always #5 clk = ~clk;

   fpmu_norm_round_pack dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_prod_mant (prod_mant),
      .i_exp_sum   (exp_sum),
      .i_sign      (sign),
      .i_in_zero   (in_zero),
      .i_in_inf    (in_inf),
      .i_in_nan    (in_nan),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_result    (result)
`ifdef FPMU_FLAGS_EN
      ,
      .o_flags     (flags)
`endif
   );

   typedef struct packed {
      logic [21:0] prod;
      logic [5:0]  es;
      logic        s;
      logic        z;
      logic        inf;
      logic        nan;
      logic [15:0] res;
      logic [3:0]  flg;
   } vec_t;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flg;
   } exp_t;

   vec_t  vecs[16];
   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endfunction

   // Monitor: the handshake seen at a negedge completes on the following posedge.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h required none", result);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               chk({nm, "_result"}, 32'(result), 32'(e.res));
`ifdef FPMU_FLAGS_EN
               chk({nm, "_flags"}, 32'(flags), 32'(e.flg));
`endif
            end
         end
      end
   end

   task automatic drive(input vec_t v, input string nm, input bit push);
      prod_mant = v.prod;
      exp_sum   = v.es;
      sign      = v.s;
      in_zero   = v.z;
      in_inf    = v.inf;
      in_nan    = v.nan;
      if (push) begin
         exp_q.push_back({v.res, v.flg});
         name_q.push_back(nm);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input vec_t v, input string nm, input bit push);
      int n;
      drive(v, nm, push);
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      vecs[0]  = '{22'h240000, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 4'h0};
      vecs[1]  = '{22'h100200, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 4'h1};
      vecs[2]  = '{22'h100600, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C02, 4'h1};
      vecs[3]  = '{22'h1FFE00, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000, 4'h1};
      vecs[4]  = '{22'h100000, 6'd50, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7C00, 4'h5};
      vecs[5]  = '{22'h100000, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 4'h3};
      vecs[6]  = '{22'h240000, 6'd30, 1'b1, 1'b1, 1'b1, 1'b0, 16'h7E00, 4'h8};
      vecs[7]  = '{22'h240000, 6'd30, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFC00, 4'h0};
      vecs[8]  = '{22'h240000, 6'd30, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 4'h0};
      vecs[9]  = '{22'h240000, 6'd30, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7E00, 4'h8};
      vecs[10] = '{22'h100000, 6'd45, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7800, 4'h0};
      vecs[11] = '{22'h100000, 6'd46, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7C00, 4'h5};
      vecs[12] = '{22'h1FFE00, 6'd45, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7C00, 4'h5};
      vecs[13] = '{22'h100000, 6'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h3};
      vecs[14] = '{22'h100000, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0400, 4'h0};
      vecs[15] = '{22'h200C00, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4002, 4'h1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(vecs[0], "init", 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", 32'(result), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: accept at edge c, out_valid visible in cycle c+3.
      send(vecs[0], "mul_1p5", 1'b1);
      chk("lat_in_ready_norm", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_in_ready_round", 32'(in_ready), 32'd0);
      chk("lat_out_valid_round", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_out_valid_done", 32'(out_valid), 32'd1);
      chk("lat_result_done", 32'(result), 32'h4080);
      drain();

      for (int i = 1; i < 16; i++) begin
         send(vecs[i], $sformatf("vec%0d", i), 1'b1);
         drain();
      end

      // Backpressure: result held in DONE, stray in_valid pulses ignored.
      out_ready = 1'b0;
      send(vecs[0], "bp_held", 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("bp_out_valid_timeout", 32'(out_valid), 32'd1);
      drive(vecs[9], "bp_stray", 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp_result_%0d", i), 32'(result), 32'h4080);
         chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
         @(posedge clk);
         #1 in_valid = (i % 2 == 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      // Release with a new operand already valid: not taken in DONE, taken in IDLE.
      out_ready = 1'b1;
      drive(vecs[2], "bp_next", 1'b1);
      in_valid = 1'b1;
      @(negedge clk);
      chk("release_in_ready_done", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("release_in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      send(vecs[3], "b2b_second", 1'b1);
      drain();

      // Reset while in ROUND discards the operation.
      send(vecs[0], "rst_flight", 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_result", 32'(result), 32'h0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (6) @(posedge clk);
      #1;
      send(vecs[15], "post_rst", 1'b1);
      drain();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
